// File: rtl/dm.sv
// Shared DMI types: scan ops, sticky status codes, request/response bundles
// and the request FSM encoding.
package dm;

    localparam int unsigned DmiAddrWidth = 7;

    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DmiNoError  = 2'd0,
        DmiOpFailed = 2'd2,
        DmiBusy     = 2'd3
    } dmi_error_e;

    typedef struct packed {
        logic [DmiAddrWidth-1:0] addr;
        dtm_op_e                 op;
        logic [31:0]             data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRead      = 3'd1,
        StWaitRead  = 3'd2,
        StWrite     = 3'd3,
        StWaitWrite = 3'd4
    } dmi_state_e;

endpackage

// File: rtl/dmi_jtag_access.sv
// DMI access register: turns DR scans under DMIACCESS into single-outstanding
// debug-module requests, keeps the sticky status and the last read data.
module dmi_jtag_access
    import dm::*;
#(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 tck_i,
    input  logic                 trst_i,
    input  logic                 test_logic_reset_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 dmi_access_i,
    input  logic                 dmi_reset_i,
    input  logic                 dmi_tdi_i,
    output logic                 dmi_tdo_o,
    output logic [1:0]           dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [DataWidth-1:0] dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [DataWidth-1:0] dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned W = AddrWidth + DataWidth + 2;

    dmi_state_e           state_q, state_d;
    logic [W-1:0]         dr_q, dr_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [1:0]           error_q, error_d;

    logic    capture, shift, update;
    logic    update_accept;
    logic    in_wait;
    logic    resp_hs;
    dtm_op_e scan_op;

    assign capture = dmi_access_i & capture_dr_i;
    assign shift   = dmi_access_i & shift_dr_i;
    assign update  = dmi_access_i & update_dr_i;
    assign scan_op = dtm_op_e'(dr_q[1:0]);

    // A scan is only acted on with a clean status and no request in flight.
    assign update_accept = update && (error_q == DmiNoError) && (state_q == StIdle);
    assign in_wait       = (state_q == StWaitRead) || (state_q == StWaitWrite);
    assign resp_hs       = in_wait && dmi_resp_valid_i;

    // Register every piece of TCK-domain state.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q <= StIdle;
            dr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= '0;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    // Shift register, address/data latches and sticky status update.
    always_comb begin
        dr_d    = dr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        error_d = error_q;

        // The status sits in the op slot so a scan reads it back for free.
        if (capture) begin
            dr_d = {addr_q, data_q, error_q};
        end else if (shift) begin
            dr_d = {dmi_tdi_i, dr_q[W-1:1]};
        end

        if (update_accept && (scan_op == DtmRead || scan_op == DtmWrite)) begin
            addr_d = dr_q[W-1 -: AddrWidth];
        end
        if (update_accept && scan_op == DtmWrite) begin
            data_d = dr_q[DataWidth+1:2];
        end

        // Write responses carry no data, so only a read refreshes data_q.
        if (resp_hs && state_q == StWaitRead) begin
            data_d = dmi_resp_data_i;
        end

        if (resp_hs && dmi_resp_resp_i != 2'd0 && error_q == DmiNoError) begin
            error_d = DmiOpFailed;
        end
        // Busy wins over a response landing in the same cycle: the scan
        // was issued while the request was still outstanding.
        if (update && error_q == DmiNoError && state_q != StIdle) begin
            error_d = DmiBusy;
        end
        if (dmi_reset_i) begin
            error_d = DmiNoError;
        end

        // Test-Logic-Reset wipes the register contents but leaves the FSM
        // running so the debug-module handshake is never torn.
        if (test_logic_reset_i) begin
            dr_d    = '0;
            addr_d  = '0;
            data_d  = '0;
            error_d = '0;
        end
    end

    // Request/response FSM next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (update_accept && scan_op == DtmRead) begin
                    state_d = StRead;
                end else if (update_accept && scan_op == DtmWrite) begin
                    state_d = StWrite;
                end
            end
            StRead:      if (dmi_req_ready_i)  state_d = StWaitRead;
            StWrite:     if (dmi_req_ready_i)  state_d = StWaitWrite;
            StWaitRead:  if (dmi_resp_valid_i) state_d = StIdle;
            StWaitWrite: if (dmi_resp_valid_i) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        dmi_req_valid_o  = 1'b0;
        dmi_req_op_o     = DtmNop;
        dmi_resp_ready_o = 1'b0;
        unique case (state_q)
            StRead: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = DtmRead;
            end
            StWrite: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = DtmWrite;
            end
            StWaitRead, StWaitWrite: dmi_resp_ready_o = 1'b1;
            default: ;
        endcase
    end

    assign dmi_req_addr_o = addr_q;
    assign dmi_req_data_o = data_q;
    assign dmi_error_o    = error_q;
    assign dmi_tdo_o      = dr_q[0];

endmodule
